// File: rtl/stream_fifo_pkg.sv
// stream_fifo_pkg: default geometry and a power-of-two depth check shared by the FIFO files
package stream_fifo_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_ENTRIES = 16;
  function automatic bit is_pow2(input int n);
    return n >= 2 && (n & (n - 1)) == 0;
  endfunction
endpackage

// File: rtl/stream_fifo_ram.sv
// simple_dual_port_ram: one write port, one registered read port, no reset on contents
module simple_dual_port_ram #(
  parameter int WIDTH = 8,
  parameter int ENTRIES = 16,
  localparam int ADDR_W = $clog2(ENTRIES)
) (
  input  logic              wclk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              rclk,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);
  logic [WIDTH-1:0] mem [ENTRIES];
  always_ff @(posedge wclk)
    if (we) mem[waddr] <= wdata;
  always_ff @(posedge rclk)
    rdata <= mem[raddr];
endmodule

// File: rtl/stream_fifo.sv
// stream_fifo: valid/ready FIFO over a 1-cycle-latency RAM, presenting the head word fall-through
module stream_fifo
  import stream_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ENTRIES = DEF_ENTRIES
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(ENTRIES):0]   count
);
  localparam int ADDR_W = $clog2(ENTRIES);
  localparam int PTR_W = ADDR_W + 1;
  if (!is_pow2(ENTRIES)) begin : g_bad_depth
    $error("stream_fifo: ENTRIES must be a power of two >= 2");
  end
  logic [PTR_W-1:0] wr_ptr, rd_ptr, wr_ptr_d1, wr_ptr_next, rd_ptr_next, wr_ptr_d1_next;
  logic push, pop;
  assign push = in_valid && in_ready;
  assign pop = out_valid && out_ready;
  assign count = wr_ptr - rd_ptr;
  assign in_ready = !rst && count != PTR_W'(ENTRIES);
  assign wr_ptr_next = wr_ptr + PTR_W'(push);
  assign rd_ptr_next = rd_ptr + PTR_W'(pop);
  assign wr_ptr_d1_next = wr_ptr;
  // Validity trails writes by one cycle so a read colliding with a same-cycle write is never shown
  always_ff @(posedge clk)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      wr_ptr_d1 <= '0;
      out_valid <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr_next;
      rd_ptr <= rd_ptr_next;
      wr_ptr_d1 <= wr_ptr_d1_next;
      out_valid <= wr_ptr_d1_next != rd_ptr_next;
    end
  always_comb
    if (!rst) assert (out_valid == (wr_ptr_d1 != rd_ptr));
  simple_dual_port_ram #(.WIDTH(WIDTH), .ENTRIES(ENTRIES)) u_ram (
    .wclk(clk),
    .we(push),
    .waddr(wr_ptr[ADDR_W-1:0]),
    .wdata(in_data),
    .rclk(clk),
    .raddr(rd_ptr_next[ADDR_W-1:0]),
    .rdata(out_data)
  );
endmodule

// File: tb/tb_stream_fifo.sv
// tb_stream_fifo: directed and backpressure stimulus against a scoreboard queue and pop monitor
module tb_stream_fifo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] in_data = '0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [7:0] out_data;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [4:0] count;
  int n_pass = 0;
  int n_chk = 0;
  int n_pop = 0;
  logic [7:0] exp_q[$];
  logic prev_hold = 1'b0;
  logic [7:0] prev_d = '0;
  always #5 clk = ~clk;
  stream_fifo #(.WIDTH(8), .ENTRIES(16)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .count(count)
  );
  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic smp();
    @(negedge clk);
  endtask
  task automatic do_reset();
    cyc();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    smp();
    chk("rst_in_ready", in_ready, 0);
    cyc();
    rst = 1'b0;
    smp();
    chk("rst_count", count, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready_after", in_ready, 1);
  endtask
  always @(negedge clk)
    if (rst) exp_q.delete();
    else if (in_valid && in_ready) exp_q.push_back(in_data);
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("pop_unexpected", 1, 0);
      else chk("out_data", out_data, exp_q.pop_front());
      n_pop++;
    end
    if (!rst && prev_hold) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, prev_d);
    end
    prev_hold = !rst && out_valid && !out_ready;
    prev_d = out_data;
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    int pushed, n0;
    // first-word latency and hold under backpressure
    do_reset();
    cyc(); in_valid = 1'b1; in_data = 8'hA5;
    smp(); chk("t1_c0_valid", out_valid, 0);
    cyc(); in_valid = 1'b0;
    smp(); chk("t1_c1_valid", out_valid, 0); chk("t1_c1_count", count, 1);
    cyc();
    smp(); chk("t1_c2_valid", out_valid, 1); chk("t1_c2_data", out_data, 8'hA5); chk("t1_c2_count", count, 1);
    repeat (3) begin
      cyc(); smp(); chk("t1_hold_valid", out_valid, 1); chk("t1_hold_count", count, 1);
    end
    cyc(); out_ready = 1'b1;
    smp();
    cyc(); out_ready = 1'b0;
    smp(); chk("t1_empty_count", count, 0); chk("t1_empty_valid", out_valid, 0);
    // fill to full, reject 17th, pop one
    do_reset();
    for (int i = 0; i < 16; i++) begin
      cyc(); in_valid = 1'b1; in_data = 8'(8'h10 + i);
    end
    cyc(); in_data = 8'hEE;
    smp(); chk("t2_full_count", count, 16); chk("t2_full_ready", in_ready, 0);
    cyc();
    smp(); chk("t2_reject_count", count, 16);
    cyc(); out_ready = 1'b1;
    smp(); chk("t2_pop_ready_same", in_ready, 0); chk("t2_pop_valid", out_valid, 1);
    cyc(); out_ready = 1'b0;
    smp(); chk("t2_after_pop_count", count, 15); chk("t2_after_pop_ready", in_ready, 1);
    cyc(); in_valid = 1'b0;
    smp(); chk("t2_refill_count", count, 16);
    // streaming from full with pointer wrap
    for (int j = 0; j < 40; j++) begin
      cyc(); in_valid = 1'b1; out_ready = 1'b1; in_data = 8'(8'h40 + j);
      smp(); chk("t4_count", count, j == 0 ? 16 : 15);
    end
    cyc(); in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 40 && count != 0; k++) begin
      cyc(); smp();
    end
    chk("t4_drain_count", count, 0);
    out_ready = 1'b0;
    chk("t4_sb_empty", exp_q.size(), 0);
    // sustained 1 word/cycle
    do_reset();
    n0 = n_pop;
    for (int i = 0; i < 100; i++) begin
      cyc(); in_valid = 1'b1; in_data = 8'(i); out_ready = 1'b1;
      smp(); chk("t3_count_le2", int'(count <= 2), 1);
    end
    cyc(); in_valid = 1'b0;
    smp();
    cyc(); smp();
    cyc(); smp();
    chk("t3_pops", n_pop - n0, 100);
    chk("t3_count", count, 0);
    out_ready = 1'b0;
    // random backpressure
    do_reset();
    pushed = 0;
    for (int c = 0; c < 40000 && pushed < 10000; c++) begin
      cyc();
      in_valid = $urandom_range(0, 3) != 0;
      in_data = 8'(pushed * 7 + 3);
      out_ready = $urandom_range(0, 3) != 0;
      smp();
      if (in_valid && in_ready) pushed++;
    end
    chk("t5_pushed", pushed, 10000);
    cyc(); in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 40 && count != 0; k++) begin
      cyc(); smp();
    end
    chk("t5_drain_count", count, 0);
    chk("t5_sb_empty", exp_q.size(), 0);
    out_ready = 1'b0;
    // reset mid-burst
    do_reset();
    for (int i = 0; i < 7; i++) begin
      cyc(); in_valid = 1'b1; in_data = 8'(8'h60 + i);
    end
    cyc(); in_valid = 1'b0;
    smp(); chk("t6_count7", count, 7);
    cyc(); rst = 1'b1; in_valid = 1'b1; in_data = 8'h99;
    smp(); chk("t6_rst_ready", in_ready, 0);
    cyc(); rst = 1'b0; in_valid = 1'b0;
    smp(); chk("t6_count0", count, 0); chk("t6_valid0", out_valid, 0); chk("t6_ready1", in_ready, 1);
    cyc(); in_valid = 1'b1; in_data = 8'h11;
    smp();
    cyc(); in_valid = 1'b0;
    smp();
    for (int k = 0; k < 5 && !out_valid; k++) begin
      cyc(); smp();
    end
    chk("t6_first_valid", out_valid, 1);
    chk("t6_first_data", out_data, 8'h11);
    cyc(); out_ready = 1'b1;
    smp();
    cyc(); out_ready = 1'b0;
    smp(); chk("t6_final_count", count, 0); chk("t6_sb_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
